// File: rtl/keyboard_pkg.sv
// Shared PS/2 keyboard definitions: keycode type, scan-code set 2 prefixes, frame states
// and the game key codes used by both the decoder and the key-toggle consumers.
package keyboard_pkg;

    localparam int unsigned KEYCODE_WIDTH = 9;
    typedef logic [KEYCODE_WIDTH-1:0] keycode_t;

    localparam logic [7:0]  PS2_EXT        = 8'hE0;
    localparam logic [7:0]  PS2_REL        = 8'hF0;
    localparam logic [7:0]  PS2_PAUSE      = 8'hE1;
    localparam int unsigned PAUSE_TAIL_LEN = 7;

    localparam keycode_t KEY_UP    = 9'h06C;
    localparam keycode_t KEY_DOWN  = 9'h075;
    localparam keycode_t KEY_LEFT  = 9'h073;
    localparam keycode_t KEY_RIGHT = 9'h14A;
    localparam keycode_t KEY_SHOOT = 9'h15A;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, clock glitch filter,
// start/data/parity/stop framing and inter-bit timeout.
module ps2_frame_rx
    import keyboard_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_error
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       clk_sync_q, data_sync_q;
    logic             filt_q, filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    rx_state_e        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_error_q, frame_error_d;
    logic             bit_evt;
    logic             sample;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_q    <= 2'b11;
            data_sync_q   <= 2'b11;
            filt_q        <= 1'b1;
            filt_cnt_q    <= '0;
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_ok_q      <= 1'b0;
            tmo_q         <= '0;
            byte_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            clk_sync_q    <= {clk_sync_q[0], ps2_clk};
            data_sync_q   <= {data_sync_q[0], ps2_data};
            filt_q        <= filt_d;
            filt_cnt_q    <= filt_cnt_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_ok_q      <= par_ok_d;
            tmo_q         <= tmo_d;
            byte_valid_q  <= byte_valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    // The filtered clock only follows after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign bit_evt = filt_q & ~filt_d;
    assign sample  = data_sync_q[1];

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_ok_d      = par_ok_q;
        tmo_d         = '0;
        byte_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        if (state_q != StIdle && !bit_evt) begin
            tmo_d = tmo_q + 1'b1;
        end
        case (state_q)
            StIdle: begin
                if (bit_evt) begin
                    if (!sample) begin
                        state_d   = StData;
                        bit_cnt_d = '0;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (bit_evt) begin
                    shift_d   = {sample, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StParity;
                    end
                end
            end
            StParity: begin
                if (bit_evt) begin
                    par_ok_d = odd_parity_ok(shift_q, sample);
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (bit_evt) begin
                    if (par_ok_q && sample) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A stalled frame wins over a coincident bit event.
        if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYCLES)) begin
            state_d       = StIdle;
            tmo_d         = '0;
            byte_valid_d  = 1'b0;
            frame_error_d = 1'b1;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign rx_byte     = shift_q;
    assign frame_error = frame_error_q;

endmodule

// File: rtl/ps2_keyboard_decoder.sv
// PS/2 scan-code set 2 decoder: folds E0/F0/E1 prefixes from received bytes into a
// {ext, byte} keyCode with one-cycle make/brake strobes.
module ps2_keyboard_decoder #(
    parameter int unsigned KEYCODE_WIDTH  = 9,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps2_clk,
    input  logic                     ps2_data,
    output logic [KEYCODE_WIDTH-1:0] keyCode,
    output logic                     make,
    output logic                     brake,
    output logic                     frame_error
);

    import keyboard_pkg::keycode_t;
    import keyboard_pkg::PS2_EXT;
    import keyboard_pkg::PS2_REL;
    import keyboard_pkg::PS2_PAUSE;
    import keyboard_pkg::PAUSE_TAIL_LEN;

    logic       byte_valid;
    logic [7:0] rx_byte;
    logic       rx_error;

    keycode_t   key_code_q, key_code_d;
    logic       make_q, make_d;
    logic       brake_q, brake_d;
    logic       ext_q, ext_d;
    logic       rel_q, rel_d;
    logic [2:0] pause_q, pause_d;

    ps2_frame_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_error(rx_error)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code_q <= '0;
            make_q     <= 1'b0;
            brake_q    <= 1'b0;
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            pause_q    <= '0;
        end else begin
            key_code_q <= key_code_d;
            make_q     <= make_d;
            brake_q    <= brake_d;
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            pause_q    <= pause_d;
        end
    end

    always_comb begin
        key_code_d = key_code_q;
        make_d     = 1'b0;
        brake_d    = 1'b0;
        ext_d      = ext_q;
        rel_d      = rel_q;
        pause_d    = pause_q;
        if (rx_error) begin
            // Drop any half-built prefix so a corrupted sequence cannot leak into the next key.
            ext_d   = 1'b0;
            rel_d   = 1'b0;
            pause_d = '0;
        end else if (byte_valid) begin
            if (pause_q != '0) begin
                pause_d = pause_q - 1'b1;
            end else begin
                case (rx_byte)
                    PS2_EXT:   ext_d   = 1'b1;
                    PS2_REL:   rel_d   = 1'b1;
                    PS2_PAUSE: pause_d = 3'(PAUSE_TAIL_LEN);
                    default: begin
                        key_code_d = {ext_q, rx_byte};
                        make_d     = ~rel_q;
                        brake_d    = rel_q;
                        ext_d      = 1'b0;
                        rel_d      = 1'b0;
                    end
                endcase
            end
        end
    end

    assign keyCode     = key_code_q;
    assign make        = make_q;
    assign brake       = brake_q;
    assign frame_error = rx_error;

endmodule

// File: tb/tb_ps2_keyboard_decoder.sv
// Scoreboard bench for ps2_keyboard_decoder: frames are bit-banged on the PS/2 pins, a
// behavioural decoder model queues expected strobes and a monitor thread checks them.
module tb_ps2_keyboard_decoder;
    import keyboard_pkg::*;

    localparam int unsigned TMO  = 200;
    localparam int          HALF = 20;

    localparam int EvMake  = 0;
    localparam int EvBrake = 1;
    localparam int EvErr   = 2;
    localparam int EvBad   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [8:0] keyCode;
    logic       make, brake, frame_error;

    int tests;
    int failed;

    typedef struct {
        int         kind;
        logic [8:0] code;
    } ev_t;
    ev_t exp_q[$];

    logic       ext_m, rel_m;
    int         pause_m;
    logic [8:0] key_m;

    always #5 clk = ~clk;

    ps2_keyboard_decoder #(
        .KEYCODE_WIDTH (9),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keyCode    (keyCode),
        .make       (make),
        .brake      (brake),
        .frame_error(frame_error)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic push_ev(input int kind, input logic [8:0] code);
        ev_t e;
        e.kind = kind;
        e.code = code;
        exp_q.push_back(e);
    endtask

    // Scan-code set 2 rules applied to one good byte.
    task automatic model_byte(input logic [7:0] b);
        if (pause_m > 0) begin
            pause_m--;
        end else if (b == 8'hE0) begin
            ext_m = 1'b1;
        end else if (b == 8'hF0) begin
            rel_m = 1'b1;
        end else if (b == 8'hE1) begin
            pause_m = 7;
        end else begin
            key_m = {ext_m, b};
            push_ev(rel_m ? EvBrake : EvMake, key_m);
            ext_m = 1'b0;
            rel_m = 1'b0;
        end
    endtask

    task automatic model_error();
        push_ev(EvErr, key_m);
        ext_m   = 1'b0;
        rel_m   = 1'b0;
        pause_m = 0;
    endtask

    task automatic model_reset();
        ext_m   = 1'b0;
        rel_m   = 1'b0;
        pause_m = 0;
        key_m   = '0;
    endtask

    // Device drives data while the clock is high; the host samples on the falling edge.
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            wait_clk(HALF / 2);
            ps2_clk = 1'b0;
            wait_clk(HALF);
            ps2_clk = 1'b1;
            wait_clk(HALF / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic p;
        p = (~^b) ^ bad_par;
        if (bad_par || bad_stop) model_error();
        else model_byte(b);
        send_bits({~bad_stop, p, b, 1'b0}, 11);
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send_frame(seq[i], 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_clk(1);
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        model_reset();
        wait_clk(5);
        check("reset_keycode", 32'(keyCode), 32'(key_m));
        check("reset_make", 32'(make), 0);
        check("reset_brake", 32'(brake), 0);
        check("reset_frame_error", 32'(frame_error), 0);
        reset = 1'b0;
        wait_clk(5);

        fork
            forever begin
                @(negedge clk);
                if (!reset && (make || brake || frame_error)) begin
                    int  gk;
                    ev_t e;
                    gk = (make && !brake && !frame_error) ? EvMake :
                         (brake && !make && !frame_error) ? EvBrake :
                         (frame_error && !make && !brake) ? EvErr : EvBad;
                    tests++;
                    if (exp_q.size() == 0) begin
                        failed++;
                        $display("FAIL unexpected_strobe: got kind=%0d keyCode=%03h, required none",
                                 gk, keyCode);
                    end else begin
                        e = exp_q.pop_front();
                        if (gk != e.kind || keyCode !== e.code) begin
                            failed++;
                            $display("FAIL strobe: got kind=%0d keyCode=%03h, required kind=%0d keyCode=%03h",
                                     gk, keyCode, e.kind, e.code);
                        end
                    end
                end
            end
        join_none

        // Plain make, release, extended keys and prefix clearing.
        send_frame(KEY_DOWN[7:0], 1'b0, 1'b0);
        send_seq('{8'hF0, KEY_DOWN[7:0]});
        send_seq('{8'hE0, KEY_RIGHT[7:0], 8'hE0, 8'hF0, KEY_RIGHT[7:0], KEY_SHOOT[7:0]});
        // Parity error leaves keyCode alone, then the same key decodes.
        send_frame(KEY_UP[7:0], 1'b1, 1'b0);
        send_frame(KEY_UP[7:0], 1'b0, 1'b0);
        // Pause sequence swallows its tail.
        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h5A});
        // Stalled frame times out.
        model_error();
        send_bits({6'h00, 4'b1010, 1'b0}, 5);
        wait_clk(TMO + 50);
        send_frame(KEY_LEFT[7:0], 1'b0, 1'b0);
        // Short clock glitches never count as bit events.
        for (int i = 0; i < 5; i++) begin
            ps2_clk = 1'b0;
            wait_clk(3);
            ps2_clk = 1'b1;
            wait_clk(20);
        end
        // Bad start bit, and a bad stop bit that must discard a pending E0.
        model_error();
        send_bits(11'h001, 1);
        wait_clk(10);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h4A, 1'b0, 1'b1);
        send_frame(8'h4A, 1'b0, 1'b0);
        // Typematic repeat.
        send_seq('{8'h1D, 8'h1D, 8'h1D});
        drain();

        // Reset mid-frame with a pending E0 prefix.
        send_frame(8'hE0, 1'b0, 1'b0);
        send_bits({8'h00, 2'b11, 1'b0}, 3);
        reset = 1'b1;
        model_reset();
        wait_clk(3);
        check("midreset_keycode", 32'(keyCode), 32'(key_m));
        reset = 1'b0;
        wait_clk(5);
        send_frame(8'h4A, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int         r;
            logic [7:0] b;
            logic       bad;
            logic       which;
            r = int'($urandom_range(0, 15));
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r == 4) b = 8'hE1;
            else b = 8'($urandom);
            bad   = ($urandom_range(0, 9) == 0);
            which = 1'($urandom_range(0, 1));
            send_frame(b, bad & which, bad & ~which);
            wait_clk(int'($urandom_range(0, 8)));
        end

        drain();
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
